tft_rx_checker: RTL
===================

# tft_rx_checker

Receive-side checker for the 800x480 RGB565 TFT parallel interface. It samples `tft_rgb`, `tft_hs`, `tft_vs` and `tft_de` on the pixel clock and measures frame geometry and HS period. It locks onto a stable frame stream and verifies every active pixel against the 4-row x 2-column colour-bar pattern. It sits on the loopback/monitor side of the TFT output path for board bring-up and simulation self-check.

## Interface
Parameters:
- `H_ACT`, 800: expected active pixels per line (DE-high cycles).
- `V_ACT`, 480: expected active lines per frame.
- `H_SPLIT`, 400: first x of colour column 1.
- `V_BAND`, 120: lines per colour row.
- `SYNC_POL`, 0: active level of `tft_hs`/`tft_vs` (0 = active-low).
- `LOCK_FRAMES`, 2: consecutive good-geometry frames required to lock.

Ports:
- `clk` in 1: pixel clock, 33 MHz. Same clock as the TFT source.
- `rst` in 1: reset, synchronous, active-high.
- `tft_rgb` in 16: RGB565 pixel.
- `tft_hs` in 1: line sync.
- `tft_vs` in 1: frame sync.
- `tft_de` in 1: data enable.
- `locked` out 1: geometry lock achieved.
- `frame_ok` out 1: one-cycle pulse at the end of a frame with correct geometry.
- `frame_cnt` out 16: VS active edges seen; wraps.
- `meas_h` out 12: width of the last active line of the previous frame.
- `meas_v` out 12: active lines in the previous frame.
- `meas_htotal` out 12: clocks between the last two HS active edges.
- `pix_err_cnt` out 16: mismatched pixels while locked; saturates at 0xFFFF.
- `lost_cnt` out 8: LOCKED->SYNC transitions; saturates at 0xFF.

## Operation
- Input stage: all four inputs are registered once (stage s1), then registered again (s2) for edge detection. All logic works on s1/s2.
- Active edges: VS edge = s1 active && s2 inactive. HS edge is defined the same way. DE fall = s2 high && s1 low.
- Pixel x counter: increments on each s1 DE-high cycle, clears after each DE fall, saturates at 4095.
- Line counter: increments on each DE fall, saturates at 4095.
- Per-frame `bad` flag: set at a DE fall when x != `H_ACT`.
- HS period counter: free-running; on an HS edge it loads `meas_htotal` and restarts at 1.
- Expected colour: row r = y / `V_BAND` (clamped to 3); column c = (x >= `H_SPLIT`). Colour index 2r+c maps in order to 0000, 001F, F800, F81F, 07E0, 07FF, FFE0, FFFF.
- Pixel check: on each s1 DE-high cycle in LOCKED, if `tft_rgb` != expected, increment `pix_err_cnt`.
- Frame end on each VS edge:
  - latch `meas_v` = line count and `meas_h` = last captured width;
  - increment `frame_cnt`;
  - evaluate good = (line count == `V_ACT`) && !bad;
  - then clear the line count, x and `bad`.
- FSM, reset state SEARCH:
  - SEARCH: on the first VS edge go to SYNC with goodcnt=0. Geometry is not evaluated for this partial frame.
  - SYNC: on a VS edge, if good then goodcnt++; when goodcnt reaches `LOCK_FRAMES` go to LOCKED. If not good, goodcnt=0.
  - LOCKED: on a VS edge, if good then pulse `frame_ok`. If not good, go to SYNC, set goodcnt=0, increment `lost_cnt`.
- `frame_ok` also pulses in SYNC for good frames.
- `locked` = (state == LOCKED).

## Timing
- Reset: every output is 0; FSM is in SEARCH; all counters and flags are 0. `rst` mid-frame returns the block to SEARCH, so the next partial frame is ignored.
- Pin-to-event latency: a VS edge at the pins updates `meas_h`, `meas_v`, `frame_cnt`, `frame_ok` and the state 3 clocks later (2 register stages plus 1 for the registered outputs).
- `pix_err_cnt` updates 2 clocks after the offending pixel at the pins.
- A DE fall and a VS edge in the same cycle: the DE fall is counted first, so the line is included in `meas_v` and in the width check.
- DE high while VS is active: pixels and lines are counted normally. There is no special case.
- Counter wrap/saturation follows the port definitions. The x counter saturating at 4095 makes the frame bad when `H_ACT` < 4095.

## Test plan
- Nominal stream: 800x480 colour bars with `SYNC_POL`=0, 4 frames. Required: `locked`=1 after the 3rd VS edge; `meas_h`=800; `meas_v`=480; `pix_err_cnt`=0; `frame_ok` pulses on the 2nd, 3rd and 4th VS edges.
- Single corrupt pixel: while locked, force pixel (x=400, y=120) to F800 instead of F81F. Required: `pix_err_cnt`=1; `locked` stays 1.
- Short line: while locked, line 200 has 799 DE cycles. Required: at that frame's VS edge, `locked`=0, `lost_cnt`=1, no `frame_ok`, `meas_h`=800. Relock after 2 further good frames.
- Wrong height: frames with 479 lines from reset. Required: `meas_v`=479; never locked; `frame_cnt` increments on every VS edge.
- HS period: HS every 1056 clocks. Required: `meas_htotal`=1056 after the second HS edge.
- Reset mid-frame: assert `rst` at line 240. Required: all outputs 0 in the next cycle. The following VS edge only enters SYNC; lock arrives 2 good frames after that.

Source files
------------

// File: rtl/tft_rx_checker.sv
// Receive-side checker for a parallel RGB565 TFT stream: measures frame
// geometry and HS period, locks on stable frames and checks colour bars.
module tft_rx_checker #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 480,
  parameter int H_SPLIT     = 400,
  parameter int V_BAND      = 120,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tft_rgb,
  input  logic        tft_hs,
  input  logic        tft_vs,
  input  logic        tft_de,
  output logic        locked,
  output logic        frame_ok,
  output logic [15:0] frame_cnt,
  output logic [11:0] meas_h,
  output logic [11:0] meas_v,
  output logic [11:0] meas_htotal,
  output logic [15:0] pix_err_cnt,
  output logic [7:0]  lost_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic        ACT_LVL = (SYNC_POL != 0);
  localparam logic [11:0] H_ACT_W = 12'(H_ACT);
  localparam logic [11:0] V_ACT_W = 12'(V_ACT);
  localparam logic [11:0] HSPL_W  = 12'(H_SPLIT);
  localparam logic [11:0] VB1_W   = 12'(V_BAND);
  localparam logic [11:0] VB2_W   = 12'(2 * V_BAND);
  localparam logic [11:0] VB3_W   = 12'(3 * V_BAND);
  localparam logic [7:0]  LF_W    = 8'(LOCK_FRAMES);

  logic [15:0] rgb_s1_q;
  logic        hs_s1_q, vs_s1_q, de_s1_q;
  logic        hs_s2_q, vs_s2_q, de_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_s1_q <= '0;
      hs_s1_q  <= ~ACT_LVL;
      vs_s1_q  <= ~ACT_LVL;
      de_s1_q  <= 1'b0;
      hs_s2_q  <= ~ACT_LVL;
      vs_s2_q  <= ~ACT_LVL;
      de_s2_q  <= 1'b0;
    end else begin
      rgb_s1_q <= tft_rgb;
      hs_s1_q  <= tft_hs;
      vs_s1_q  <= tft_vs;
      de_s1_q  <= tft_de;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
      de_s2_q  <= de_s1_q;
    end
  end

  logic vs_edge, hs_edge, de_fall;
  assign vs_edge = (vs_s1_q == ACT_LVL) && (vs_s2_q != ACT_LVL);
  assign hs_edge = (hs_s1_q == ACT_LVL) && (hs_s2_q != ACT_LVL);
  assign de_fall = de_s2_q && !de_s1_q;

  // Frame end runs one cycle after the VS edge so a coincident DE fall is
  // already folded into the line count, width and bad flag.
  logic        fe_q;
  logic [11:0] x_q, x_d, line_q, line_d, last_w_q, last_w_d, htot_q;
  logic        bad_q, bad_d;

  always_comb begin
    x_d      = x_q;
    line_d   = line_q;
    bad_d    = bad_q;
    last_w_d = last_w_q;
    if (de_fall) begin
      line_d   = (line_q == 12'hFFF) ? line_q : line_q + 12'd1;
      last_w_d = x_q;
      x_d      = '0;
      if (x_q != H_ACT_W) bad_d = 1'b1;
    end else if (de_s1_q) begin
      x_d = (x_q == 12'hFFF) ? x_q : x_q + 12'd1;
    end
    if (fe_q) begin
      line_d = de_fall ? 12'd1 : 12'd0;
      bad_d  = de_fall && (x_q != H_ACT_W);
      x_d    = de_s1_q ? 12'd1 : 12'd0;
    end
  end

  logic [1:0]  row;
  logic [2:0]  cidx;
  logic [15:0] exp_rgb;

  always_comb begin
    row = 2'd0;
    if (line_q >= VB3_W)      row = 2'd3;
    else if (line_q >= VB2_W) row = 2'd2;
    else if (line_q >= VB1_W) row = 2'd1;
    cidx = {row, (x_q >= HSPL_W)};
    case (cidx)
      3'd0:    exp_rgb = 16'h0000;
      3'd1:    exp_rgb = 16'h001F;
      3'd2:    exp_rgb = 16'hF800;
      3'd3:    exp_rgb = 16'hF81F;
      3'd4:    exp_rgb = 16'h07E0;
      3'd5:    exp_rgb = 16'h07FF;
      3'd6:    exp_rgb = 16'hFFE0;
      default: exp_rgb = 16'hFFFF;
    endcase
  end

  state_e      state_q, state_d;
  logic [7:0]  goodcnt_q, goodcnt_d;
  logic        frame_ok_d, lost_inc, good;

  assign good = (line_q == V_ACT_W) && !bad_q;

  always_comb begin
    state_d    = state_q;
    goodcnt_d  = goodcnt_q;
    frame_ok_d = 1'b0;
    lost_inc   = 1'b0;
    if (fe_q) begin
      case (state_q)
        ST_SEARCH: begin
          state_d   = ST_SYNC;
          goodcnt_d = '0;
        end
        ST_SYNC: begin
          if (good) begin
            frame_ok_d = 1'b1;
            goodcnt_d  = goodcnt_q + 8'd1;
            if (goodcnt_q + 8'd1 >= LF_W) state_d = ST_LOCKED;
          end else begin
            goodcnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            frame_ok_d = 1'b1;
          end else begin
            state_d   = ST_SYNC;
            goodcnt_d = '0;
            lost_inc  = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  logic pix_mis;
  assign pix_mis = de_s1_q && (state_q == ST_LOCKED) && (rgb_s1_q != exp_rgb);

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_q        <= 1'b0;
      x_q         <= '0;
      line_q      <= '0;
      bad_q       <= 1'b0;
      last_w_q    <= '0;
      htot_q      <= '0;
      state_q     <= ST_SEARCH;
      goodcnt_q   <= '0;
      frame_ok    <= 1'b0;
      frame_cnt   <= '0;
      meas_h      <= '0;
      meas_v      <= '0;
      meas_htotal <= '0;
      pix_err_cnt <= '0;
      lost_cnt    <= '0;
    end else begin
      fe_q      <= vs_edge;
      x_q       <= x_d;
      line_q    <= line_d;
      bad_q     <= bad_d;
      last_w_q  <= last_w_d;
      state_q   <= state_d;
      goodcnt_q <= goodcnt_d;
      frame_ok  <= frame_ok_d;
      if (hs_edge) begin
        meas_htotal <= htot_q;
        htot_q      <= 12'd1;
      end else begin
        htot_q <= htot_q + 12'd1;
      end
      if (fe_q) begin
        meas_v    <= line_q;
        meas_h    <= last_w_q;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (pix_mis && pix_err_cnt != 16'hFFFF) pix_err_cnt <= pix_err_cnt + 16'd1;
      if (lost_inc && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign dbg_state = state_q;

endmodule
